gray_weighted_unmixer: RTL and testbench
========================================

GRAY_WEIGHTED_UNMIXER -- requirements
Module: gray_weighted_unmixer

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port gray_mix_in  input  8  merged gray sample, truncated weighted average of gray1 and gray2.
REQ-004 SHALL have port gray1_in  input  8  known first-source gray sample.
REQ-005 SHALL have port weight1  input  8  weight applied to gray1 when the mix was formed.
REQ-006 SHALL have port weight2  input  8  weight applied to the unknown gray2.
REQ-007 SHALL have port in_valid  input  1  input operands valid.
REQ-008 SHALL have port in_ready  output  1  block can accept operands.
REQ-009 SHALL have port gray2_out  output  8  recovered second-source gray sample.
REQ-010 SHALL have port out_valid  output  1  gray2_out and flags valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port sat_flag  output  1  result was clamped, to 0 or to 255.
REQ-013 SHALL have port div_err  output  1  weight2 was zero.

Function
REQ-014 SHALL compute gray2 = (gray_mix*(w1+w2) - gray1*w1) / w2 with unsigned truncating division, using registered operand copies.
REQ-015 SHALL use numerator width 18 bits signed; the positive range reaches 130050 and needs 17 bits.
REQ-016 SHALL implement states IDLE, PREP, DIV and DONE.
REQ-017 IDLE: in_ready=1; an accept occurs when in_valid && in_ready. On accept: latch all four operands and go to PREP.
REQ-018 PREP (1 cycle): form the numerator and branch on the first matching case, in this order:
- w2==0: result 0, div_err=1, go to DONE.
- numerator<0: result 0, sat_flag=1, go to DONE.
- otherwise: load the divider and go to DIV.
REQ-019 DIV: run exactly 17 restoring-division iterations (17-bit dividend, 8-bit divisor), one per cycle, then go to DONE.
REQ-020 SHALL clamp a quotient above 255 to 255 and set sat_flag=1; otherwise gray2_out = quotient[7:0] and sat_flag=0.
REQ-021 DONE: hold out_valid=1 with stable outputs until out_ready=1, then return to IDLE in that same cycle.
REQ-022 in_ready SHALL be 0 in PREP, DIV and DONE; input changes outside IDLE SHALL be ignored.
REQ-023 Latency, normal path: out_valid SHALL assert 19 cycles after the accept edge (1 PREP + 17 DIV + 1 registering).
REQ-024 Latency, PREP short-circuit: out_valid SHALL assert 2 cycles after the accept edge.
REQ-025 In IDLE, out_valid, sat_flag and div_err SHALL be 0; gray2_out SHALL retain its last value.
REQ-026 Back-to-back: a new accept is possible the cycle after the DONE handshake; no overlap of operations.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-DIV, asynchronously set state=IDLE and abandon any in-flight operation.
REQ-028 Reset values SHALL be: in_ready=0 while asserted, gray2_out=0, out_valid=0, sat_flag=0, div_err=0, divider registers=0.
REQ-029 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-030 Package gray_pkg SHALL hold GRAY_W=8, WEIGHT_W=8, NUM_W=18, DIV_ITER=17 and the unmixer state enum.
REQ-031 The division SHALL be a sub-module serial_divider with start/busy/done handshake, 17-bit dividend, 8-bit divisor, 17-bit quotient.
REQ-032 The two products SHALL be formed once, in PREP; the multipliers SHALL NOT sit in the DIV path.

Verification
REQ-033 Unity weights: mix=100, g1=50, w1=1, w2=1 -> gray2_out=150, flags 0, out_valid exactly 19 cycles after accept.
REQ-034 Unequal weights: mix=120, g1=90, w1=2, w2=3 -> gray2_out=140, sat_flag=0.
REQ-035 Saturation, both sides:
- mix=255, g1=0, w1=1, w2=1 -> gray2_out=255, sat_flag=1.
- mix=0, g1=200, w1=3, w2=1 -> gray2_out=0, sat_flag=1, 2-cycle latency.
REQ-036 Zero divisor: w2=0 -> gray2_out=0, div_err=1, 2-cycle latency; next valid op clears div_err.
REQ-037 Backpressure and reset:
- out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0.
- rst_n pulsed at DIV iteration 8 -> out_valid=0, in_ready=1 after release.
REQ-038 Random round-trip: for random g1, g2, w1, w2 with w2>0, feed the merger's truncated mix in; require |gray2_out - g2| <= ceil((w1+w2)/w2) unless sat_flag=1.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared widths, iteration count and FSM state type for the gray unmixer.
package gray_pkg;
    localparam int GRAY_W   = 8;
    localparam int WEIGHT_W = 8;
    localparam int NUM_W    = 18;
    localparam int DIV_ITER = 17;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        DIV,
        DONE
    } unmix_state_t;
endpackage

// File: rtl/gray_weighted_unmixer_serial_divider.sv
// Restoring serial divider: one quotient bit per cycle, done pulses with the final quotient.
module serial_divider
    import gray_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DIV_ITER-1:0] dividend,
    input  logic [WEIGHT_W-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [DIV_ITER-1:0] quotient
);
    logic [DIV_ITER-1:0] quot_reg;
    logic [WEIGHT_W-1:0] rem_reg;
    logic [WEIGHT_W-1:0] dvsr_reg;
    logic [4:0]          cnt_reg;
    logic                busy_reg;
    logic                done_reg;

    logic [WEIGHT_W:0]   shifted;
    logic                fits;

    // The remainder stays below the divisor, so the shifted trial value needs one extra bit.
    assign shifted = {rem_reg, quot_reg[DIV_ITER-1]};
    assign fits    = (shifted >= {1'b0, dvsr_reg});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_reg <= '0;
            rem_reg  <= '0;
            dvsr_reg <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                quot_reg <= dividend;
                rem_reg  <= '0;
                dvsr_reg <= divisor;
                cnt_reg  <= 5'(DIV_ITER);
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                rem_reg  <= fits ? WEIGHT_W'(shifted - {1'b0, dvsr_reg}) : shifted[WEIGHT_W-1:0];
                quot_reg <= {quot_reg[DIV_ITER-2:0], fits};
                cnt_reg  <= cnt_reg - 5'd1;
                if (cnt_reg == 5'd1) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign quotient = quot_reg;
endmodule

// File: rtl/gray_weighted_unmixer.sv
// Recovers gray2 from a truncated weighted mix: (mix*(w1+w2) - g1*w1) / w2, clamped to 0..255.
module gray_weighted_unmixer
    import gray_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [GRAY_W-1:0]   gray_mix_in,
    input  logic [GRAY_W-1:0]   gray1_in,
    input  logic [WEIGHT_W-1:0] weight1,
    input  logic [WEIGHT_W-1:0] weight2,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [GRAY_W-1:0]   gray2_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sat_flag,
    output logic                div_err
);
    unmix_state_t state_reg, state_next;

    logic [GRAY_W-1:0]   mix_reg, g1_reg;
    logic [WEIGHT_W-1:0] w1_reg, w2_reg;
    logic [GRAY_W-1:0]   gray2_reg, gray2_next;
    logic                sat_reg, sat_next;
    logic                err_reg, err_next;
    logic                valid_reg, valid_next;

    logic [WEIGHT_W:0]   wsum;
    logic [16:0]         prod_mix;
    logic [15:0]         prod_g1;
    logic signed [NUM_W-1:0] num;

    logic                div_start, div_busy, div_done;
    logic [DIV_ITER-1:0] div_quot;
    logic                accept;

    // Products come from the latched operands and are only consumed while in PREP.
    assign wsum     = {1'b0, w1_reg} + {1'b0, w2_reg};
    assign prod_mix = mix_reg * wsum;
    assign prod_g1  = g1_reg * w1_reg;
    assign num      = $signed({1'b0, prod_mix}) - $signed({2'b00, prod_g1});

    assign accept   = in_valid && (state_reg == IDLE);
    assign in_ready = (state_reg == IDLE) && rst_n;

    serial_divider u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (num[DIV_ITER-1:0]),
        .divisor  (w2_reg),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mix_reg   <= '0;
            g1_reg    <= '0;
            w1_reg    <= '0;
            w2_reg    <= '0;
            gray2_reg <= '0;
            sat_reg   <= 1'b0;
            err_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            gray2_reg <= gray2_next;
            sat_reg   <= sat_next;
            err_reg   <= err_next;
            valid_reg <= valid_next;
            if (accept) begin
                mix_reg <= gray_mix_in;
                g1_reg  <= gray1_in;
                w1_reg  <= weight1;
                w2_reg  <= weight2;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        gray2_next = gray2_reg;
        sat_next   = sat_reg;
        err_next   = err_reg;
        valid_next = valid_reg;
        div_start  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = PREP;
            end
            PREP: begin
                if (w2_reg == '0) begin
                    gray2_next = '0;
                    err_next   = 1'b1;
                    sat_next   = 1'b0;
                    state_next = DONE;
                end else if (num < 0) begin
                    gray2_next = '0;
                    err_next   = 1'b0;
                    sat_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    div_start  = 1'b1;
                    state_next = DIV;
                end
            end
            DIV: begin
                if (div_done && !div_busy) begin
                    if (div_quot > DIV_ITER'(255)) begin
                        gray2_next = 8'hFF;
                        sat_next   = 1'b1;
                    end else begin
                        gray2_next = div_quot[GRAY_W-1:0];
                        sat_next   = 1'b0;
                    end
                    err_next   = 1'b0;
                    valid_next = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // Short-circuit results arrive without valid; raise it one cycle later.
                if (!valid_reg) begin
                    valid_next = 1'b1;
                end else if (out_ready) begin
                    valid_next = 1'b0;
                    sat_next   = 1'b0;
                    err_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign gray2_out = gray2_reg;
    assign out_valid = valid_reg;
    assign sat_flag  = sat_reg;
    assign div_err   = err_reg;
endmodule

// File: tb/tb_gray_weighted_unmixer.sv
// Directed and randomized bench for gray_weighted_unmixer against an arithmetic reference model.
module tb_gray_weighted_unmixer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] gray_mix_in, gray1_in, weight1, weight2;
    logic       in_valid, in_ready, out_valid, out_ready, sat_flag, div_err;
    logic [7:0] gray2_out;

    int checks   = 0;
    int failures = 0;

    gray_weighted_unmixer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gray_mix_in (gray_mix_in),
        .gray1_in    (gray1_in),
        .weight1     (weight1),
        .weight2     (weight2),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .gray2_out   (gray2_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sat_flag    (sat_flag),
        .div_err     (div_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one operation from IDLE (called #1 after a rising edge) through its handshake.
    task automatic run_op(input logic [7:0] mix, input logic [7:0] g1, input logic [7:0] w1,
                          input logic [7:0] w2, input int stall,
                          output logic [7:0] got, output logic got_sat);
        int num, q, exp_q, exp_lat, lat, busy_bad;
        logic exp_sat, exp_err;
        num = int'(mix) * (int'(w1) + int'(w2)) - int'(g1) * int'(w1);
        exp_sat = 1'b0; exp_err = 1'b0; exp_lat = 2;
        if (w2 == 0) begin
            exp_q = 0; exp_err = 1'b1;
        end else if (num < 0) begin
            exp_q = 0; exp_sat = 1'b1;
        end else begin
            q = num / int'(w2);
            exp_lat = 19;
            if (q > 255) begin exp_q = 255; exp_sat = 1'b1; end
            else exp_q = q;
        end
        gray_mix_in = mix; gray1_in = g1; weight1 = w1; weight2 = w2;
        in_valid = 1'b1; out_ready = 1'b0;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        lat = 0; busy_bad = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            in_valid = 1'($urandom_range(0, 1));
            gray_mix_in = 8'($urandom); gray1_in = 8'($urandom);
            weight1 = 8'($urandom); weight2 = 8'($urandom);
            if (in_ready !== 1'b0) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, exp_lat);
        check("busy_in_ready", busy_bad, 0);
        check("gray2_out", gray2_out, exp_q);
        check("sat_flag", sat_flag, exp_sat);
        check("div_err", div_err, exp_err);
        got = gray2_out; got_sat = sat_flag;
        repeat (stall) begin
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1);
            check("stall_gray2", gray2_out, exp_q);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_flags", {sat_flag, div_err}, 0);
        check("post_retain", gray2_out, exp_q);
        $display("op mix=%0d g1=%0d w1=%0d w2=%0d -> gray2=%0d sat=%0d err=%0d lat=%0d",
                 mix, g1, w1, w2, got, got_sat, exp_err, lat);
    endtask

    initial begin
        logic [7:0] got, g1, g2, w1, w2, mix;
        logic       got_sat;
        int         diff, tol;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        gray_mix_in = '0; gray1_in = '0; weight1 = '0; weight2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_gray2", gray2_out, 0);
        check("rst_flags", {sat_flag, div_err}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", in_ready, 1);

        run_op(8'd100, 8'd50, 8'd1, 8'd1, 0, got, got_sat);
        run_op(8'd120, 8'd90, 8'd2, 8'd3, 0, got, got_sat);
        run_op(8'd255, 8'd0, 8'd1, 8'd1, 0, got, got_sat);
        run_op(8'd0, 8'd200, 8'd3, 8'd1, 0, got, got_sat);
        run_op(8'd77, 8'd10, 8'd5, 8'd0, 0, got, got_sat);
        run_op(8'd120, 8'd90, 8'd2, 8'd3, 5, got, got_sat);
        run_op(8'd200, 8'd200, 8'd0, 8'd255, 0, got, got_sat);

        // Reset in the middle of the division.
        gray_mix_in = 8'd100; gray1_in = 8'd50; weight1 = 8'd1; weight2 = 8'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_gray2", gray2_out, 0);
        #2 rst_n = 1'b1;
        #1;
        check("midrst_release_ready", in_ready, 1);
        @(posedge clk); #1;
        check("midrst_out_valid_after", out_valid, 0);
        $display("reset pulsed mid-division");
        run_op(8'd100, 8'd50, 8'd1, 8'd1, 2, got, got_sat);

        for (int i = 0; i < 30; i++) begin
            g1 = 8'($urandom); g2 = 8'($urandom);
            w1 = 8'($urandom); w2 = 8'($urandom_range(1, 255));
            mix = 8'((int'(g1) * int'(w1) + int'(g2) * int'(w2)) / (int'(w1) + int'(w2)));
            run_op(mix, g1, w1, w2, int'($urandom_range(0, 2)), got, got_sat);
            if (!got_sat) begin
                diff = int'(got) - int'(g2);
                if (diff < 0) diff = -diff;
                tol = (int'(w1) + int'(w2) + int'(w2) - 1) / int'(w2);
                check("roundtrip_within_tol", 32'(diff <= tol), 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
